// File: rtl/ring_mon.sv
// Ring-counter monitor: checks a one-hot 4-bit ring for legal rotation, tracks lock and revolutions.
// Define RING_MON_ERRCNT_EN to build the saturating 8-bit error counter on err_cnt (tied to 0 otherwise).
module ring_mon #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned REV_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ring_in,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_vld,
  output logic             rev_tick,
  output logic [REV_W-1:0] rev_cnt,
  output logic             lock,
  output logic             resync,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_sticky,
  output logic [7:0]       err_cnt
);

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_INVALID,
    CLS_FIRST,
    CLS_HOLD,
    CLS_ADV,
    CLS_JUMP,
    CLS_BAD
  } cls_e;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_LOCKING,
    ST_LOCKED
  } state_e;

  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [REV_W-1:0] REV_ONE   = REV_W'(1);

  logic [3:0]       cur_q;
  logic [3:0]       prev_q;
  logic             samp_vld_q;
  logic             first_q;
  state_e           state_q;
  state_e           state_d;
  logic [3:0]       adv_cnt_q;
  logic [3:0]       adv_cnt_d;
  logic [1:0]       phase_q;
  logic             phase_vld_q;
  logic             rev_tick_q;
  logic [REV_W-1:0] rev_cnt_q;
  logic             lock_q;
  logic             resync_q;
  logic             err_onehot_q;
  logic             err_seq_q;
  logic             err_sticky_q;

  cls_e       cls;
  logic       cur_onehot;
  logic [3:0] prev_rotl;
  logic [1:0] cur_enc;
  logic       rev_event;
  logic       err_event;

  assign cur_onehot = (cur_q != 4'd0) && ((cur_q & (cur_q - 4'd1)) == 4'd0);
  assign prev_rotl  = {prev_q[2:0], prev_q[3]};
  assign cur_enc    = {cur_q[2] | cur_q[3], cur_q[1] | cur_q[3]};

  // cur_q holds no real sample until the first edge after reset; samp_vld_q keeps
  // that reset value from being reported as a one-hot error.
  always_comb begin
    cls = CLS_NONE;
    if (!samp_vld_q) begin
      cls = CLS_NONE;
    end else if (!cur_onehot) begin
      cls = CLS_INVALID;
    end else if (first_q) begin
      cls = CLS_FIRST;
    end else if (cur_q == prev_q) begin
      cls = CLS_HOLD;
    end else if (cur_q == prev_rotl) begin
      cls = CLS_ADV;
    end else if (cur_q == 4'b1000 && prev_q != 4'b1000 && prev_q != 4'b0100) begin
      cls = CLS_JUMP;
    end else begin
      cls = CLS_BAD;
    end
  end

  assign rev_event = (cls == CLS_ADV) && (prev_q == 4'b1000);
  assign err_event = (cls == CLS_INVALID) || (cls == CLS_BAD);

  always_comb begin
    state_d   = state_q;
    adv_cnt_d = adv_cnt_q;
    case (cls)
      CLS_INVALID: begin
        state_d   = ST_UNLOCKED;
        adv_cnt_d = 4'd0;
      end
      CLS_FIRST, CLS_JUMP: begin
        state_d   = ST_LOCKING;
        adv_cnt_d = 4'd0;
      end
      CLS_ADV: begin
        case (state_q)
          ST_UNLOCKED: begin
            state_d   = ST_LOCKING;
            adv_cnt_d = 4'd0;
          end
          ST_LOCKING: begin
            if (adv_cnt_q == LOCK_LAST) begin
              state_d   = ST_LOCKED;
              adv_cnt_d = 4'd0;
            end else begin
              adv_cnt_d = adv_cnt_q + 4'd1;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
      CLS_BAD: begin
        // A bad step is still a one-hot sample, so an unlocked monitor starts locking on it.
        state_d   = (state_q == ST_UNLOCKED) ? ST_LOCKING : ST_UNLOCKED;
        adv_cnt_d = 4'd0;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q        <= 4'd0;
      prev_q       <= 4'd0;
      samp_vld_q   <= 1'b0;
      first_q      <= 1'b1;
      state_q      <= ST_UNLOCKED;
      adv_cnt_q    <= 4'd0;
      phase_q      <= 2'd0;
      phase_vld_q  <= 1'b0;
      rev_tick_q   <= 1'b0;
      rev_cnt_q    <= '0;
      lock_q       <= 1'b0;
      resync_q     <= 1'b0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      cur_q      <= ring_in;
      prev_q     <= cur_q;
      samp_vld_q <= 1'b1;
      if (cls == CLS_INVALID) begin
        first_q <= 1'b1;
      end else if (cls == CLS_FIRST) begin
        first_q <= 1'b0;
      end
      state_q   <= state_d;
      adv_cnt_q <= adv_cnt_d;
      if (samp_vld_q && cur_onehot) begin
        phase_q <= cur_enc;
      end
      phase_vld_q  <= samp_vld_q & cur_onehot;
      rev_tick_q   <= rev_event;
      lock_q       <= (state_d == ST_LOCKED);
      resync_q     <= (cls == CLS_JUMP);
      err_onehot_q <= (cls == CLS_INVALID);
      err_seq_q    <= (cls == CLS_BAD);
      if (rev_event && state_d == ST_LOCKED) begin
        rev_cnt_q <= rev_cnt_q + REV_ONE;
      end
      err_sticky_q <= err_event | (err_sticky_q & ~clr_err);
    end
  end

`ifdef RING_MON_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (err_event) begin
      if (err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end else if (clr_err) begin
      err_cnt_q <= 8'd0;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

  assign phase      = phase_q;
  assign phase_vld  = phase_vld_q;
  assign rev_tick   = rev_tick_q;
  assign rev_cnt    = rev_cnt_q;
  assign lock       = lock_q;
  assign resync     = resync_q;
  assign err_onehot = err_onehot_q;
  assign err_seq    = err_seq_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: doc/ring_mon.md
RING_MON -- requirements
Module: ring_mon

Interface
REQ-001 Parameter LOCK_CNT, default 4: number of consecutive legal advances needed to reach LOCKED; legal range 1..15.
REQ-002 Parameter REV_W, default 8: width of rev_cnt.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ring_in  input  4  one-hot ring value from the upstream ring counter; legal sequence is 1000 -> 0001 -> 0010 -> 0100 -> 1000.
REQ-006 clr_err  input  1  synchronous clear of err_sticky.
REQ-007 phase  output  2  encoded phase: 0001=0, 0010=1, 0100=2, 1000=3.
REQ-008 phase_vld  output  1  high when phase reflects a one-hot sample.
REQ-009 rev_tick  output  1  one-cycle pulse per completed revolution.
REQ-010 rev_cnt  output  REV_W  revolutions counted while LOCKED.
REQ-011 lock  output  1  high in state LOCKED.
REQ-012 resync  output  1  one-cycle pulse on a legal jump to 1000.
REQ-013 err_onehot, err_seq  output  1 each  one-cycle error pulses.
REQ-014 err_sticky  output  1  latched OR of all error pulses.
REQ-015 err_cnt  output  8  saturating error count; present only with the macro enabled (see Configuration).

Function
REQ-016 ring_in shall be registered into cur_q, and cur_q shall be copied into prev_q each cycle; all outputs shall be registered, so latency from ring_in to outputs is 2 clk.
REQ-017 Sample classification of (prev_q, cur_q), with first = no valid prior sample since reset or since the last non-one-hot sample:
- invalid: cur_q not one-hot (0000 or more than one bit set).
- advance: cur_q == rotate-left(prev_q).
- hold: cur_q == prev_q.
- jump: cur_q == 1000 and prev_q is neither 1000 nor 0100.
- bad: any other valid-to-valid transition.
REQ-018 invalid shall pulse err_onehot, clear phase_vld, and set first.
REQ-019 bad shall pulse err_seq; err_seq shall never assert when first is set.
REQ-020 jump shall pulse resync and shall not be an error.
REQ-021 rev_tick shall pulse on an advance from 1000 to 0001, in any FSM state.
REQ-022 FSM states:
- UNLOCKED -> LOCKING on any one-hot sample.
- LOCKING -> LOCKED after LOCK_CNT advances.
- LOCKING -> UNLOCKED on invalid or bad.
- LOCKING stays LOCKING on jump, with the advance counter zeroed.
- LOCKED -> UNLOCKED on invalid or bad.
- LOCKED -> LOCKING on jump.
- hold: no state change, no count change.
REQ-023 rev_cnt shall increment on rev_tick only while lock is high, and shall wrap modulo 2^REV_W.
REQ-024 err_sticky shall set on any error pulse and clear on clr_err; if both occur in the same cycle, set wins.

Reset
REQ-025 While rst_n is low, all registers shall clear asynchronously:
- cur_q = prev_q = 0000, first = 1, state = UNLOCKED.
- phase = 0; phase_vld, rev_tick, resync, lock, err_onehot, err_seq, err_sticky = 0.
- rev_cnt = 0, err_cnt = 0.
REQ-026 Release of rst_n shall take effect on the next rising clk edge; a reset asserted mid-revolution shall discard all lock progress.

Configuration
REQ-027 Macro RING_MON_ERRCNT_EN defined: err_cnt shall increment on each err_onehot or err_seq pulse, saturate at 255, and clear on clr_err (increment wins if simultaneous).
REQ-028 Macro RING_MON_ERRCNT_EN undefined: err_cnt shall be constant 0 and no counter logic shall be synthesized.

Verification
REQ-029 Reset released, ring_in rotating from 1000 with LOCK_CNT=4 -> lock rises 2 clk after the 5th sample (the 4th advance); phase follows 3,0,1,2 lagging by 2 clk.
REQ-030 Locked, 8 full revolutions -> 8 rev_tick pulses, rev_cnt=8; at REV_W=8, 256 revolutions -> rev_cnt=0.
REQ-031 Locked, ring_in forced to 0110 for 1 cycle -> err_onehot pulse, phase_vld=0, lock=0, err_sticky=1, no err_seq on the following valid sample.
REQ-032 Locked, 0001 -> 0100 -> err_seq pulse, state UNLOCKED; 0010 -> 1000 -> resync pulse, lock=0, no error.
REQ-033 ring_in held at 1000 for 10 cycles -> no errors, no advances, state unchanged.
REQ-034 clr_err and an err_seq in the same cycle -> err_sticky stays 1; with RING_MON_ERRCNT_EN, 300 errors -> err_cnt=255.
